i2s_capture_ctrl: RTL and testbench
===================================

Name: i2s_capture_ctrl

Overview:
- Sequences the I2S receiver's sample stream into stereo frame captures.
- On `start`, aligns to a left-channel sample, pairs left/right 16-bit samples into 32-bit frames and buffers them in a FWFT FIFO.
- Stops after a programmed frame count, or on `stop`.
- Sits between the I2S receiver (`data`/`dataflag`/`WS`) and the downstream consumer, which reads through a valid/ready port.

Parameters:
- FIFO_DEPTH, 8, frame FIFO entries; power of 2, ≥2.
- CNT_W, 16, width of frame-count config and counter.

Ports:
- clk  in  1  system clock, same domain as the I2S receiver.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; arms a capture.
- stop  in  1  single-cycle pulse; ends capture early.
- num_frames  in  CNT_W  frames to capture; 0 = continuous until `stop`; sampled on the accepted `start`.
- ws  in  1  receiver word-select; 0 = left, 1 = right.
- sample_data  in  16  receiver sample word.
- sample_valid  in  1  receiver `dataflag`; 1-cycle pulse per sample.
- out_data  out  32  FIFO head; {left[15:0], right[15:0]}.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts head when high with `out_valid`.
- busy  out  1  high in SYNC/CAPT_L/CAPT_R.
- done  out  1  high in DONE.
- overflow  out  1  sticky; frame dropped on full FIFO.
- sync_err  out  1  1-cycle pulse on channel misorder.
- frames  out  CNT_W  frames pushed this capture.

Behaviour:
- Reset (async, immediate): state=IDLE, FIFO emptied, all outputs 0, out_data=0, pending left cleared.
- Channel of a sample = `ws` sampled in the same cycle as `sample_valid`.
- States:
  - IDLE: `start` → SYNC; latch `num_frames`; clear `frames` and `overflow`. FIFO contents are not flushed.
  - SYNC: discard samples until a sample_valid with ws=0 → hold it as pending left → CAPT_R.
  - CAPT_R: sample_valid with ws=1 → form frame {left, sample}, push → CAPT_L. Sample_valid with ws=0 → `sync_err` pulse, replace pending left, stay.
  - CAPT_L: sample_valid with ws=0 → hold left → CAPT_R. Sample_valid with ws=1 → `sync_err` pulse, discard, stay.
  - DONE: `start` → SYNC (re-arm, same as IDLE); otherwise hold.
- Push and count:
  - A push that is accepted increments `frames`.
  - When `frames` reaches the latched nonzero `num_frames` on that push, the next state is DONE instead of CAPT_L.
- Full FIFO:
  - Push is accepted if a pop occurs in the same cycle.
  - Otherwise the frame is dropped, `overflow` is set, `frames` is unchanged, and the state still advances to CAPT_L.
- `stop` in SYNC/CAPT_L/CAPT_R → IDLE; pending left is discarded. If `stop` coincides with a completing right sample, the push happens first, then IDLE.
- `start` while busy is ignored; `stop` in IDLE/DONE is ignored.
- FIFO is first-word fall-through:
  - Pop when out_valid & out_ready.
  - Latency: right sample accepted at cycle t with FIFO empty → out_valid=1, out_data valid at t+1.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- `frames` saturates at all-ones in continuous mode.

Optional Feature:
- Macro: I2S_CAPTURE_DROP_CNT_EN.
- Defined: adds output `drop_count` (16 bits). It increments on each dropped frame and each sync_err, saturates at 0xFFFF, clears on accepted `start` and on reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- num_frames=4, out_ready=1, samples L=0x1111/R=0x2222 repeated → exactly 4 frames of 0x11112222, then done=1, busy=0, frames=4.
- Start with first sample ws=1 (0xAAAA) then L=0x0001, R=0x0002 → 0xAAAA discarded; first out_data=0x00010002.
- Sequence L=0x0003, L=0x0004, R=0x0005 → one sync_err pulse; frame 0x00040005.
- num_frames=0, out_ready=0, 10 pairs with FIFO_DEPTH=8 → 8 frames buffered, overflow=1, frames=8; set out_ready=1 → 8 frames drained in order; `stop` → IDLE.
- Assert rst mid-CAPT_R with 3 frames in FIFO → out_valid=0, busy=0, frames=0, overflow=0 immediately; no frame emitted for the pending left.
- Full FIFO, out_ready=1 and right sample in the same cycle → frame accepted, no overflow, FIFO stays full.

Source files
------------

// File: rtl/i2s_capture_ctrl.sv
// I2S stereo frame capture: pairs left/right samples into 32-bit frames and buffers them in a FWFT FIFO.
// Optional drop/sync-error counter output is enabled with I2S_CAPTURE_DROP_CNT_EN.
module i2s_capture_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_frames,
    input  logic             ws,
    input  logic [15:0]      sample_data,
    input  logic             sample_valid,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             sync_err,
    output logic [CNT_W-1:0] frames
`ifdef I2S_CAPTURE_DROP_CNT_EN
    ,
    output logic [15:0]      drop_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_CAPT_L, S_CAPT_R, S_DONE} state_t;

    state_t           r_state, w_state_next;
    logic [15:0]      r_left, w_left_next;
    logic [CNT_W-1:0] r_num, w_num_next;
    logic [CNT_W-1:0] r_frames, w_frames_next, w_frames_inc;
    logic             r_overflow, w_overflow_next;
    logic             r_sync_err, w_sync_err;
    logic             w_start_acc;
    logic             w_push_req, w_push, w_pop, w_full, w_empty;
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr, r_rd_ptr;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop        = !w_empty && out_ready;
    assign w_push_req   = (r_state == S_CAPT_R) && sample_valid && ws;
    // A full FIFO still takes the frame when the head leaves in the same cycle.
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_frames_inc = r_frames + 1'b1;

    always_comb begin
        w_state_next    = r_state;
        w_left_next     = r_left;
        w_num_next      = r_num;
        w_frames_next   = r_frames;
        w_overflow_next = r_overflow;
        w_sync_err      = 1'b0;
        w_start_acc     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_start_acc     = 1'b1;
                    w_state_next    = S_SYNC;
                    w_num_next      = num_frames;
                    w_frames_next   = '0;
                    w_overflow_next = 1'b0;
                end
            end
            S_SYNC: begin
                if (stop) begin
                    w_state_next = S_IDLE;
                end else if (sample_valid && !ws) begin
                    w_left_next  = sample_data;
                    w_state_next = S_CAPT_R;
                end
            end
            S_CAPT_R: begin
                if (sample_valid && ws) begin
                    if (w_push && !(&r_frames))
                        w_frames_next = w_frames_inc;
                    if (!w_push)
                        w_overflow_next = 1'b1;
                    if (stop)
                        w_state_next = S_IDLE;
                    else if (w_push && (r_num != '0) && (w_frames_inc == r_num))
                        w_state_next = S_DONE;
                    else
                        w_state_next = S_CAPT_L;
                end else if (stop) begin
                    w_state_next = S_IDLE;
                end else if (sample_valid) begin
                    w_sync_err  = 1'b1;
                    w_left_next = sample_data;
                end
            end
            S_CAPT_L: begin
                if (stop) begin
                    w_state_next = S_IDLE;
                end else if (sample_valid && !ws) begin
                    w_left_next  = sample_data;
                    w_state_next = S_CAPT_R;
                end else if (sample_valid) begin
                    w_sync_err = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_state_next == S_IDLE)
            w_left_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_left     <= '0;
            r_num      <= '0;
            r_frames   <= '0;
            r_overflow <= 1'b0;
            r_sync_err <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_left     <= w_left_next;
            r_num      <= w_num_next;
            r_frames   <= w_frames_next;
            r_overflow <= w_overflow_next;
            r_sync_err <= w_sync_err;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= {r_left, sample_data};
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? 32'h0 : r_mem[r_rd_ptr[AW-1:0]];
    assign busy      = (r_state == S_SYNC) || (r_state == S_CAPT_L) || (r_state == S_CAPT_R);
    assign done      = (r_state == S_DONE);
    assign overflow  = r_overflow;
    assign sync_err  = r_sync_err;
    assign frames    = r_frames;

`ifdef I2S_CAPTURE_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_drop_cnt <= '0;
        else if (w_start_acc)
            r_drop_cnt <= '0;
        else if (((w_push_req && !w_push) || w_sync_err) && !(&r_drop_cnt))
            r_drop_cnt <= r_drop_cnt + 1'b1;
    end
    assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Directed bench for i2s_capture_ctrl: vector table plus hand sequences for FIFO-full and reset cases.
module tb_i2s_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0;
    logic [15:0] num_frames = '0;
    logic        ws = 1'b0;
    logic [15:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy, done, overflow, sync_err;
    logic [15:0] frames;
`ifdef I2S_CAPTURE_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    i2s_capture_ctrl #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .num_frames(num_frames),
        .ws(ws), .sample_data(sample_data), .sample_valid(sample_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overflow(overflow), .sync_err(sync_err),
        .frames(frames)
`ifdef I2S_CAPTURE_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    typedef struct {
        logic        start, stop, ws, sv;
        logic [15:0] data;
        logic        rdy;
        logic [15:0] num;
        logic        ov;
        logic [31:0] od;
        logic        busy, done, ovf;
        logic [15:0] frames;
        logic        serr;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(logic st, logic sp, logic w, logic v, logic [15:0] d, logic rd,
                                logic [15:0] n, logic eov, logic [31:0] eod, logic eb, logic ed,
                                logic eovf, logic [15:0] efr, logic es);
        vec_t x;
        x.start = st; x.stop = sp; x.ws = w; x.sv = v; x.data = d; x.rdy = rd; x.num = n;
        x.ov = eov; x.od = eod; x.busy = eb; x.done = ed; x.ovf = eovf; x.frames = efr; x.serr = es;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic sp, input logic w, input logic v,
                       input logic [15:0] d, input logic rd);
        @(negedge clk);
        start = st; stop = sp; ws = w; sample_valid = v; sample_data = d; out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Full-sequence vectors; expectations are the outputs just after each edge.
        //          st sp ws sv data      rdy num     ov od            bsy dn ovf fr serr
        vt[0]  = mk(1, 0, 0, 0, 16'h0000, 1, 16'd4, 0, 32'h0,        1, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 0, 1, 16'h1111, 1, 16'd4, 0, 32'h0,        1, 0, 0, 0, 0);
        vt[2]  = mk(0, 0, 1, 1, 16'h2222, 1, 16'd4, 1, 32'h11112222, 1, 0, 0, 1, 0);
        vt[3]  = mk(0, 0, 0, 1, 16'h1111, 1, 16'd4, 0, 32'h0,        1, 0, 0, 1, 0);
        vt[4]  = mk(0, 0, 1, 1, 16'h2222, 1, 16'd4, 1, 32'h11112222, 1, 0, 0, 2, 0);
        vt[5]  = mk(0, 0, 0, 1, 16'h1111, 1, 16'd4, 0, 32'h0,        1, 0, 0, 2, 0);
        vt[6]  = mk(0, 0, 1, 1, 16'h2222, 1, 16'd4, 1, 32'h11112222, 1, 0, 0, 3, 0);
        vt[7]  = mk(0, 0, 0, 1, 16'h1111, 1, 16'd4, 0, 32'h0,        1, 0, 0, 3, 0);
        vt[8]  = mk(0, 0, 1, 1, 16'h2222, 1, 16'd4, 1, 32'h11112222, 0, 1, 0, 4, 0);
        vt[9]  = mk(0, 0, 0, 0, 16'h0000, 1, 16'd4, 0, 32'h0,        0, 1, 0, 4, 0);
        vt[10] = mk(0, 0, 0, 1, 16'h1111, 1, 16'd4, 0, 32'h0,        0, 1, 0, 4, 0);
        vt[11] = mk(1, 0, 0, 0, 16'h0000, 1, 16'd4, 0, 32'h0,        1, 0, 0, 0, 0);
        vt[12] = mk(0, 0, 1, 1, 16'hAAAA, 1, 16'd4, 0, 32'h0,        1, 0, 0, 0, 0);
        vt[13] = mk(0, 0, 0, 1, 16'h0001, 1, 16'd4, 0, 32'h0,        1, 0, 0, 0, 0);
        vt[14] = mk(0, 0, 1, 1, 16'h0002, 1, 16'd4, 1, 32'h00010002, 1, 0, 0, 1, 0);
        vt[15] = mk(0, 0, 0, 1, 16'h0003, 1, 16'd4, 0, 32'h0,        1, 0, 0, 1, 0);
        vt[16] = mk(0, 0, 0, 1, 16'h0004, 1, 16'd4, 0, 32'h0,        1, 0, 0, 1, 1);
        vt[17] = mk(0, 0, 1, 1, 16'h0005, 1, 16'd4, 1, 32'h00040005, 1, 0, 0, 2, 0);
        vt[18] = mk(0, 1, 0, 0, 16'h0000, 1, 16'd4, 0, 32'h0,        0, 0, 0, 2, 0);
        vt[19] = mk(0, 1, 0, 0, 16'h0000, 1, 16'd4, 0, 32'h0,        0, 0, 0, 2, 0);

        #1;
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.out_data", out_data, 32'd0);
        chk("rst.busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst.ovf_serr", {30'd0, overflow, sync_err}, 32'd0);
        chk("rst.frames", {16'd0, frames}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            num_frames = vt[i].num;
            cyc(vt[i].start, vt[i].stop, vt[i].ws, vt[i].sv, vt[i].data, vt[i].rdy);
            chk($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vt[i].ov});
            chk($sformatf("v%0d.out_data", i), out_data, vt[i].od);
            chk($sformatf("v%0d.busy", i), {31'd0, busy}, {31'd0, vt[i].busy});
            chk($sformatf("v%0d.done", i), {31'd0, done}, {31'd0, vt[i].done});
            chk($sformatf("v%0d.overflow", i), {31'd0, overflow}, {31'd0, vt[i].ovf});
            chk($sformatf("v%0d.frames", i), {16'd0, frames}, {16'd0, vt[i].frames});
            chk($sformatf("v%0d.sync_err", i), {31'd0, sync_err}, {31'd0, vt[i].serr});
            $display("vec %0d: out_valid=%0b out_data=%h busy=%0b done=%0b frames=%0d",
                     i, out_valid, out_data, busy, done, frames);
        end

        // Continuous capture into a stalled consumer: fill, push-with-pop on full, then drops.
        num_frames = 16'd0;
        cyc(1, 0, 0, 0, 16'h0, 0);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0, 1, 16'h1000 + 16'(k), 0);
            cyc(0, 0, 1, 1, 16'h2000 + 16'(k), 0);
        end
        chk("fill.frames", {16'd0, frames}, 32'd8);
        chk("fill.overflow", {31'd0, overflow}, 32'd0);
        chk("fill.head", out_data, 32'h10002000);
        cyc(0, 0, 0, 1, 16'h1008, 0);
        cyc(0, 0, 1, 1, 16'h2008, 1);
        chk("fullpop.frames", {16'd0, frames}, 32'd9);
        chk("fullpop.overflow", {31'd0, overflow}, 32'd0);
        chk("fullpop.head", out_data, 32'h10012001);
        $display("full push+pop: frames=%0d overflow=%0b head=%h", frames, overflow, out_data);
        for (int k = 9; k < 11; k++) begin
            cyc(0, 0, 0, 1, 16'h1000 + 16'(k), 0);
            cyc(0, 0, 1, 1, 16'h2000 + 16'(k), 0);
        end
        chk("drop.frames", {16'd0, frames}, 32'd9);
        chk("drop.overflow", {31'd0, overflow}, 32'd1);
`ifdef I2S_CAPTURE_DROP_CNT_EN
        chk("drop.count", {16'd0, drop_count}, 32'd2);
`endif
        @(negedge clk);
        sample_valid = 1'b0; ws = 1'b0; out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk($sformatf("drain%0d.valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("drain%0d.data", k), out_data, {16'h1000 + 16'(k), 16'h2000 + 16'(k)});
            $display("drain %0d: out_data=%h", k, out_data);
            @(negedge clk);
        end
        #1;
        chk("drain.empty", {31'd0, out_valid}, 32'd0);
        cyc(0, 1, 0, 0, 16'h0, 1);
        chk("stop.busy", {31'd0, busy}, 32'd0);
        chk("stop.done", {31'd0, done}, 32'd0);

        // Asynchronous reset while a left sample is pending with frames buffered.
        cyc(1, 0, 0, 0, 16'h0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 1, 16'h3000 + 16'(k), 0);
            cyc(0, 0, 1, 1, 16'h4000 + 16'(k), 0);
        end
        cyc(0, 0, 0, 1, 16'h5555, 0);
        chk("prerst.frames", {16'd0, frames}, 32'd3);
        chk("prerst.busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        sample_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst.busy", {31'd0, busy}, 32'd0);
        chk("arst.frames", {16'd0, frames}, 32'd0);
        chk("arst.overflow", {31'd0, overflow}, 32'd0);
        chk("arst.out_data", out_data, 32'd0);
        $display("async reset: out_valid=%0b busy=%0b frames=%0d", out_valid, busy, frames);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 1, 1, 16'h6666, 0);
        chk("postrst.idle_right", {31'd0, out_valid}, 32'd0);
        cyc(1, 0, 0, 0, 16'h0, 0);
        cyc(0, 0, 1, 1, 16'h7777, 0);
        chk("postrst.sync_right", {31'd0, out_valid}, 32'd0);
        chk("postrst.frames", {16'd0, frames}, 32'd0);
        chk("postrst.busy", {31'd0, busy}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
